// File: rtl/seg7_pkg.sv
// seg7_pkg: 7-segment patterns (a..g, 1 = lit), scan states and the nibble encoder
package seg7_pkg;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h67;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {OFF, GUARD, SHOW} scan_state_t;

    function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction
endpackage

// File: rtl/seg7_nibble_dec.sv
// seg7_nibble_dec: combinational nibble to active-high a..g pattern, non-BCD shown as a dash
module seg7_nibble_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = seg7_encode(nib);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit BCD to 7-segment driver with inter-digit blanking guard
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 8,
    parameter int SEG_ACT_LOW  = 1,
    parameter int AN_ACT_LOW   = 1
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_start
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2((PRESCALE > BLANK_CYCLES ? PRESCALE : BLANK_CYCLES) + 1);
    localparam logic [CW-1:0] P_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] G_LAST = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] D_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);
    localparam logic [6:0] SEG_INV = SEG_ACT_LOW != 0 ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_INV = AN_ACT_LOW != 0 ? {NUM_DIGITS{1'b1}} : '0;
    localparam scan_state_t ENTRY = BLANK_CYCLES > 0 ? GUARD : SHOW;

    scan_state_t             state, n_state;
    logic [IW-1:0]           digit_idx, n_idx;
    logic [CW-1:0]           pre_cnt, n_cnt;
    logic [4*NUM_DIGITS-1:0] shadow, disp, n_shadow, n_disp;
    logic [3:0]              nib;
    logic [6:0]              pat, n_seg;
    logic [NUM_DIGITS-1:0]   n_an;
    logic                    wrap, lz;

    assign n_shadow = load ? bcd_in : shadow;
    assign wrap     = state == SHOW && pre_cnt == P_LAST && digit_idx == D_LAST;
    // disp only changes on frame boundaries (or while dark), so a frame never mixes two values
    assign n_disp   = (wrap || state == OFF) ? n_shadow : disp;

    always_comb begin
        n_state = state;
        n_idx   = digit_idx;
        n_cnt   = pre_cnt + 1'b1;
        if (!en) begin
            n_state = OFF;
            n_idx   = '0;
            n_cnt   = '0;
        end else if (state == OFF) begin
            n_state = ENTRY;
            n_idx   = '0;
            n_cnt   = '0;
        end else if (state == GUARD && pre_cnt == G_LAST) begin
            n_state = SHOW;
            n_cnt   = '0;
        end else if (state == SHOW && pre_cnt == P_LAST) begin
            n_state = ENTRY;
            n_cnt   = '0;
            n_idx   = digit_idx == D_LAST ? '0 : digit_idx + 1'b1;
        end
    end

    assign nib = 4'(n_disp >> {n_idx, 2'b00});

`ifdef SEG7_LZB_EN
    // a digit is a leading zero when it and every nibble above it are zero
    assign lz = n_idx != '0 && (n_disp >> {n_idx, 2'b00}) == '0;
`else
    assign lz = 1'b0;
`endif

    seg7_nibble_dec u_dec (
        .nib (nib),
        .seg (pat)
    );

    assign n_seg = (n_state == OFF || lz) ? SEG_BLANK : pat;
    assign n_an  = n_state == SHOW ? AN_ONE << n_idx : '0;

    // outputs are registered from next-state values so they stay aligned with the FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= OFF;
            digit_idx   <= '0;
            pre_cnt     <= '0;
            shadow      <= '0;
            disp        <= '0;
            seg_o       <= SEG_INV;
            an_o        <= AN_INV;
            frame_start <= 1'b0;
        end else begin
            state       <= n_state;
            digit_idx   <= n_idx;
            pre_cnt     <= n_cnt;
            shadow      <= n_shadow;
            disp        <= n_disp;
            seg_o       <= n_seg ^ SEG_INV;
            an_o        <= n_an ^ AN_INV;
            frame_start <= n_state == SHOW && n_idx == '0 && n_cnt == '0;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench; a frame-timing reference model predicts every output cycle
module tb_seg7_scan_driver;
    localparam int ND  = 4;
    localparam int P   = 4;
    localparam int B   = 1;
    localparam int PER = ND * (P + B);

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;
    logic        frame_start;

    int          tests = 0;
    int          fails = 0;
    exp_t        q[$];
    exp_t        cur;
    bit          m_on = 1'b0;
    int          m_t = 0;
    logic [15:0] m_sv = '0;
    logic [15:0] m_fv = '0;
    logic [6:0]  lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h67, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    seg7_scan_driver #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (P),
        .BLANK_CYCLES (B),
        .SEG_ACT_LOW  (1),
        .AN_ACT_LOW   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .bcd_in      (bcd_in),
        .seg_o       (seg_o),
        .an_o        (an_o),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    // expected outputs from the position inside the frame, t cycles after scanning started
    function automatic exp_t ref_out(input bit on, input int t, input logic [15:0] fv);
        exp_t e;
        int   pos, d, r;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.fs  = 1'b0;
        if (!on) return e;
        pos   = t % PER;
        d     = pos / (P + B);
        r     = pos % (P + B);
        e.seg = ~lut[fv[4*d +: 4]];
`ifdef SEG7_LZB_EN
        begin
            int hi;
            hi = 0;
            for (int k = 0; k < ND; k++) if (fv[4*k +: 4] != 4'd0) hi = k;
            if (d > hi) e.seg = 7'h7F;
        end
`endif
        if (r >= B) begin
            e.an = ~(4'b0001 << d);
            e.fs = d == 0 && r == B;
        end
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_on = 1'b0;
            m_sv = '0;
            m_fv = '0;
        end else begin
            if (load) m_sv = bcd_in;
            if (!en) m_on = 1'b0;
            else if (!m_on) begin
                m_on = 1'b1;
                m_t  = 0;
                m_fv = m_sv;
            end else begin
                m_t++;
                if (m_t % PER == 0) m_fv = m_sv;
            end
        end
        q.push_back(ref_out(m_on, m_t, m_fv));
    end

    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            cur = q.pop_front();
            check("an_o", {3'b0, an_o}, {3'b0, cur.an});
            check("seg_o", seg_o, cur.seg);
            check("frame_start", {6'b0, frame_start}, {6'b0, cur.fs});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        bcd_in = v;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1;
        check("rst_an", {3'b0, an_o}, 7'h0F);
        check("rst_seg", seg_o, 7'h7F);
        check("rst_fs", {6'b0, frame_start}, 7'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        pulse_reset();
        do_load(16'h1234);
        en = 1'b1;
        step(45);
        step(7);
        do_load(16'h9876);
        step(50);
        do_load(16'hFA05);
        step(45);
        step(12);
        en = 1'b0;
        step(4);
        en = 1'b1;
        step(30);
        step(7);
        pulse_reset();
        step(30);
        do_load(16'h0042);
        step(45);
        do_load(16'h0000);
        step(45);
        repeat (1500) begin
            @(negedge clk);
            load   = $urandom_range(0, 15) == 0;
            bcd_in = 16'($urandom);
            if (en ? $urandom_range(0, 149) == 0 : $urandom_range(0, 9) == 0) en = ~en;
            if ($urandom_range(0, 399) == 0) pulse_reset();
        end
        load = 1'b0;
        step(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
